// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding
// and the default instruction-address width.
package pc_sequencer_pkg;

  localparam int PC_WIDTH_DEF = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder-to-sequencer bundle: requests in, PC and stack status out.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = 8
) ();

  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic                en;
  logic                jmp;
  logic                cal;
  logic                ret;
  logic [PC_WIDTH-1:0] jmp_addr;
  logic                clr_err;
  logic [PC_WIDTH-1:0] instr_addr;
  logic [DW-1:0]       depth;
  logic                full;
  logic                empty;
  logic                overflow_err;
  logic                underflow_err;
  logic                halted;

  // Decoder side: issues requests, observes PC and status.
  modport master (
    output en, jmp, cal, ret, jmp_addr, clr_err,
    input  instr_addr, depth, full, empty, overflow_err, underflow_err, halted
  );

  // Sequencer side.
  modport slave (
    input  en, jmp, cal, ret, jmp_addr, clr_err,
    output instr_addr, depth, full, empty, overflow_err, underflow_err, halted
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. Occupancy counter is the only reset state; the
// storage array is never reset because an entry is only read after a push.
// flush empties the stack in one edge; push and pop are never both honoured.
module ret_stack #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 8,
  localparam int DW = $clog2(STACK_DEPTH + 1),
  localparam int AW = $clog2(STACK_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic [DW-1:0]       depth
);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]       cnt;
  logic [AW-1:0]       ptr;

  // ptr indexes the most recent entry; top is a pure read of it.
  assign ptr   = AW'(cnt - DW'(1));
  assign top   = mem[ptr];
  assign depth = cnt;

  // Occupancy: flush wins, then push, then pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (push) begin
      cnt <= cnt + DW'(1);
    end else if (pop) begin
      cnt <= cnt - DW'(1);
    end
  end

  // Storage write at the slot just above the current top.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[cnt[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increments, jumps, calls and returns with a
// bounded return stack. Overflow/underflow park the FSM in HALT until the
// decoder clears the error, which also restarts from RESET_ADDR.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
  parameter int                  STACK_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_ADDR  = '0,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  pc_sequencer_if.slave      bus
);

  seq_state_t          state;
  logic [PC_WIDTH-1:0] pc;
  logic                ovf;
  logic                unf;

  logic                push;
  logic                pop;
  logic                flush;
  logic [PC_WIDTH-1:0] top;
  logic [DW-1:0]       depth;
  logic                full;
  logic                empty;

  assign full  = (depth == DW'(STACK_DEPTH));
  assign empty = (depth == '0);

  // Stack commands, mirroring the priority used by the FSM below.
  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    if (bus.en) begin
      if (state == RUN) begin
        if (bus.ret) begin
          pop = !empty;
        end else if (bus.cal) begin
          push = !full;
        end
      end else if (bus.clr_err) begin
        flush = 1'b1;
      end
    end
  end

  ret_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (pc + PC_WIDTH'(1)),
    .top       (top),
    .depth     (depth)
  );

  // Sequencer FSM: next PC, error flags and RUN/HALT, all held while en=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      pc    <= RESET_ADDR;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (bus.en) begin
      case (state)
        RUN: begin
          if (bus.ret) begin
            if (empty) begin
              unf   <= 1'b1;
              state <= HALT;
            end else begin
              pc <= top;
            end
          end else if (bus.cal) begin
            if (full) begin
              ovf   <= 1'b1;
              state <= HALT;
            end else begin
              pc <= bus.jmp_addr;
            end
          end else if (bus.jmp) begin
            pc <= bus.jmp_addr;
          end else begin
            pc <= pc + PC_WIDTH'(1);
          end
        end
        HALT: begin
          if (bus.clr_err) begin
            state <= RUN;
            pc    <= RESET_ADDR;
            ovf   <= 1'b0;
            unf   <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.instr_addr    = pc;
  assign bus.depth         = depth;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.overflow_err  = ovf;
  assign bus.underflow_err = unf;
  assign bus.halted        = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (PC_WIDTH=8, STACK_DEPTH=4). Each vector
// queues its expected post-edge outputs; a monitor compares after each edge.
module tb_pc_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       halted;
  } obs_t;

  typedef struct {
    string name;
    obs_t  exp;
  } sb_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  sb_t  sb_q[$];

  pc_sequencer_if #(.PC_WIDTH(8), .STACK_DEPTH(4)) bus ();

  pc_sequencer #(
    .PC_WIDTH    (8),
    .STACK_DEPTH (4),
    .RESET_ADDR  (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.pc     = bus.instr_addr;
    o.depth  = bus.depth;
    o.full   = bus.full;
    o.empty  = bus.empty;
    o.ovf    = bus.overflow_err;
    o.unf    = bus.underflow_err;
    o.halted = bus.halted;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%h depth=%0d full=%b empty=%b ovf=%b unf=%b halted=%b",
                     o.pc, o.depth, o.full, o.empty, o.ovf, o.unf, o.halted);
  endfunction

  function automatic obs_t mk(input logic [7:0] pc, input int d,
                              input logic o, input logic u, input logic h);
    obs_t e;
    e.pc     = pc;
    e.depth  = 3'(d);
    e.full   = (d == 4);
    e.empty  = (d == 0);
    e.ovf    = o;
    e.unf    = u;
    e.halted = h;
    return e;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %s required %s", name, fmt(act), fmt(exp));
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outcome
  // expected after the following rising edge.
  task automatic step(input string name, input logic e, input logic j,
                      input logic c, input logic r, input logic ce,
                      input logic [7:0] a, input logic [7:0] xpc, input int xd,
                      input logic xo, input logic xu, input logic xh);
    sb_t s;
    @(negedge clk);
    bus.en       = e;
    bus.jmp      = j;
    bus.cal      = c;
    bus.ret      = r;
    bus.clr_err  = ce;
    bus.jmp_addr = a;
    s.name = name;
    s.exp  = mk(xpc, xd, xo, xu, xh);
    sb_q.push_back(s);
  endtask

  // Monitor: one comparison per rising edge whenever a vector is pending.
  initial begin
    sb_t s;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        check(s.name, sample(), s.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.jmp      = 1'b0;
    bus.cal      = 1'b0;
    bus.ret      = 1'b0;
    bus.clr_err  = 1'b0;
    bus.jmp_addr = 8'h00;
    #1;
    check("reset", sample(), mk(8'h00, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    //   name            en j  c  r  clr addr    pc     d  ovf unf halt
    step("hold_en0",     0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    step("inc1",         1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0);
    step("inc2",         1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0, 0);
    step("inc3",         1, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0, 0);
    step("jmp05",        1, 1, 0, 0, 0, 8'h05, 8'h05, 0, 0, 0, 0);
    step("cal40",        1, 0, 1, 0, 0, 8'h40, 8'h40, 1, 0, 0, 0);
    step("inc41",        1, 0, 0, 0, 0, 8'h00, 8'h41, 1, 0, 0, 0);
    step("ret06",        1, 0, 0, 1, 0, 8'h00, 8'h06, 0, 0, 0, 0);
    step("jmp21",        1, 1, 0, 0, 0, 8'h21, 8'h21, 0, 0, 0, 0);
    step("cal80",        1, 0, 1, 0, 0, 8'h80, 8'h80, 1, 0, 0, 0);
    step("prio_ret",     1, 1, 1, 1, 0, 8'h55, 8'h22, 0, 0, 0, 0);
    step("jmpFF",        1, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0);
    step("wrap",         1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    step("clr_in_run",   1, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0, 0);
    step("jmp10",        1, 1, 0, 0, 0, 8'h10, 8'h10, 0, 0, 0, 0);
    step("nest1",        1, 0, 1, 0, 0, 8'h20, 8'h20, 1, 0, 0, 0);
    step("nest2",        1, 0, 1, 0, 0, 8'h30, 8'h30, 2, 0, 0, 0);
    step("nest3",        1, 0, 1, 0, 0, 8'h40, 8'h40, 3, 0, 0, 0);
    step("nest4",        1, 0, 1, 0, 0, 8'h50, 8'h50, 4, 0, 0, 0);
    step("overflow",     1, 0, 1, 0, 0, 8'h60, 8'h50, 4, 1, 0, 1);
    step("halt_reqs",    1, 1, 1, 1, 0, 8'h77, 8'h50, 4, 1, 0, 1);
    step("halt_clr_en0", 0, 0, 0, 0, 1, 8'h00, 8'h50, 4, 1, 0, 1);
    step("clr_ovf",      1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    step("jmp07",        1, 1, 0, 0, 0, 8'h07, 8'h07, 0, 0, 0, 0);
    step("underflow",    1, 0, 0, 1, 0, 8'h00, 8'h07, 0, 0, 1, 1);
    step("clr_unf",      1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    step("jmp30",        1, 1, 0, 0, 0, 8'h30, 8'h30, 0, 0, 0, 0);
    step("en0_cal_a",    0, 0, 1, 0, 0, 8'h99, 8'h30, 0, 0, 0, 0);
    step("en0_cal_b",    0, 0, 1, 0, 0, 8'h99, 8'h30, 0, 0, 0, 0);
    step("en0_cal_c",    0, 0, 1, 0, 0, 8'h99, 8'h30, 0, 0, 0, 0);
    step("cal_d1",       1, 0, 1, 0, 0, 8'h40, 8'h40, 1, 0, 0, 0);
    step("cal_d2",       1, 0, 1, 0, 0, 8'h50, 8'h50, 2, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle with two entries stacked.
    @(posedge clk);
    #3;
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.cal      = 1'b0;
    bus.jmp_addr = 8'h00;
    #1;
    check("async_rst", sample(), mk(8'h00, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    step("rel_inc",      1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0, 0);
    step("rel_ret_unf",  1, 0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1, 1);
    step("rel_clr",      1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);

    @(negedge clk);
    bus.en      = 1'b0;
    bus.clr_err = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending vectors required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
